stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-input, W-bit valid/ready stream multiplexer with round-robin or fixed-priority arbitration and a single registered output stage. It generalises the team's two-input one-bit combinational mux into a sequential, flow-controlled block. It merges several producer streams onto one consumer stream, for example several request sources sharing one memory or network port. Each accepted message is tagged with the index of the input it came from.

## Interface
- nbits, default 8: message width, at least 1.
- ninputs, default 4: number of input streams, 2..16, need not be a power of two.
- rr_mode, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, where the lowest index wins.
- Derived: sbits = max(1, $clog2(ninputs)).

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_val  input  ninputs  per-input valid; bit i belongs to input i.
- in_rdy  output  ninputs  per-input ready; at most one bit high per cycle.
- in_msg  input  ninputs*nbits  flattened messages; input i uses in_msg[i*nbits +: nbits].
- out_val  output  1  output register holds a valid message.
- out_rdy  input  1  consumer ready.
- out_msg  output  nbits  registered message.
- out_sel  output  sbits  registered index of the input that supplied out_msg.

## Operation
- State:
  - full: the output register is occupied; drives out_val.
  - msg_r and sel_r: drive out_msg and out_sel.
  - ptr: round-robin priority pointer, sbits wide, value range 0..ninputs-1.
- Transfer rule: a transfer happens on any port when val && rdy are both high at the rising clock edge.
- Output drain: happens when out_val && out_rdy.
- Accept enable: acc_en = !full || out_rdy. The register can load when it is empty, or when it is draining in the same cycle.
- Grant, combinational:
  - Round-robin: the first i with in_val[i] high, scanning ptr, ptr+1, …, ninputs-1, 0, …, ptr-1.
  - Fixed priority: the lowest i with in_val[i] high.
  - If no in_val bit is high, there is no grant.
- in_rdy[i] = grant[i] && acc_en. in_rdy depends combinationally on in_val, out_rdy and state. There is no combinational path from in_msg to any output.
- On an accept from input g:
  - msg_r <= in_msg[g], sel_r <= g, full <= 1.
  - If rr_mode = 1, ptr <= (g == ninputs-1) ? 0 : g+1.
- On a drain with no accept in the same cycle: full <= 0. msg_r and sel_r keep their old values; they are don't-care while out_val = 0.
- With no accept, ptr is unchanged. In particular it does not advance on valid-without-ready cycles.
- While out_val = 1 and out_rdy = 0, out_msg and out_sel must hold stable.
- An input that has raised in_val is not required by this block to hold it. The bench drives stable val/msg until transfer.

## Timing
- Reset values: out_val = 0, out_msg = 0, out_sel = 0, ptr = 0, full = 0. in_rdy is all 0 during any cycle in which rst is high.
- Reset mid-operation: a held message is dropped. The first accept after reset uses ptr = 0.
- Latency: input transfer on edge k gives out_val = 1 and the message on out_msg after edge k, in cycle k+1.
- Throughput: 1 message per cycle when out_rdy is held high and any in_val is high.
- Full and out_rdy = 0: all in_rdy are 0 and no state changes.
- Full and out_rdy = 1: drain and accept happen on the same edge, with no bubble.
- Empty and no in_val: idle, no state change.
- Wrap-around: a grant to index ninputs-1 sets ptr to 0. This must hold for non-power-of-two ninputs, and ptr never takes a value ≥ ninputs.
- Fairness: with rr_mode = 1 and all inputs continuously valid, every input is served exactly once in every window of ninputs accepts.

## Test plan
- Reset and single input (ninputs=4, nbits=8):
  - Stimulus: hold rst high 2 cycles, then pulse in_val[2] with msg 0xA5 while out_rdy = 1.
  - Required: out_val = 0 during reset. in_rdy[2] = 1 that cycle. Next cycle out_val = 1, out_msg = 0xA5, out_sel = 2.
- Round-robin contention:
  - Stimulus: all 4 inputs valid with msgs 0x10, 0x11, 0x12, 0x13 held, out_rdy = 1, for 8 cycles.
  - Required: out_sel sequence 0,1,2,3,0,1,2,3, with one output per cycle.
- Backpressure:
  - Stimulus: load 0x55 from input 1, hold out_rdy = 0 for 3 cycles with input 3 valid, then raise out_rdy.
  - Required: out_msg stays 0x55 and out_sel stays 1. in_rdy is all 0 during the stall. On the release edge 0x55 drains and input 3 is accepted on that same edge. The next cycle shows out_sel = 3.
- Fixed priority (rr_mode=0):
  - Stimulus: inputs 0 and 2 continuously valid, out_rdy = 1.
  - Required: out_sel = 0 every cycle and in_rdy[2] is never 1.
- Wrap, non-power-of-two (ninputs=3):
  - Stimulus: only input 2 valid for one transfer, then inputs 0 and 1 valid.
  - Required: ptr wraps to 0, so the next out_sel is 0, then 1.
- Mid-operation reset:
  - Stimulus: assert rst while full with out_rdy = 0.
  - Required: next cycle out_val = 0. The first subsequent grant with inputs 1 and 3 valid goes to 1.

Source files
------------

// File: rtl/stream_mux_rr.sv
// N-input valid/ready stream multiplexer with round-robin or fixed-priority arbitration
// and a single registered output stage; each message is tagged with its source index.
module stream_mux_rr #(
  parameter int unsigned nbits   = 8,
  parameter int unsigned ninputs = 4,
  parameter bit          rr_mode = 1'b1,
  localparam int unsigned sbits  = (ninputs > 1) ? $clog2(ninputs) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ninputs-1:0]         in_val,
  output logic [ninputs-1:0]         in_rdy,
  input  logic [ninputs*nbits-1:0]   in_msg,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [nbits-1:0]           out_msg,
  output logic [sbits-1:0]           out_sel
);

  logic             full_q, full_d;
  logic [nbits-1:0] msg_q, msg_d;
  logic [sbits-1:0] sel_q, sel_d;
  logic [sbits-1:0] ptr_q, ptr_d;

  logic             grant_found;
  logic [sbits-1:0] grant_idx;
  logic [sbits:0]   scan_idx;
  logic             acc_en;
  logic             accept;
  logic [nbits-1:0] lanes [ninputs];

  for (genvar i = 0; i < ninputs; i++) begin : g_lanes
    assign lanes[i] = in_msg[i*nbits +: nbits];
  end

  // Round-robin scans ptr, ptr+1, ... modulo ninputs; the extra bit of scan_idx
  // lets the wrap be done by a single compare-and-subtract.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    if (rr_mode) begin
      for (int off = 0; off < ninputs; off++) begin
        scan_idx = {1'b0, ptr_q} + (sbits+1)'(off);
        if (scan_idx >= (sbits+1)'(ninputs)) begin
          scan_idx = scan_idx - (sbits+1)'(ninputs);
        end
        if (!grant_found && in_val[scan_idx[sbits-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = scan_idx[sbits-1:0];
        end
      end
    end else begin
      for (int i = ninputs - 1; i >= 0; i--) begin
        if (in_val[i]) begin
          grant_found = 1'b1;
          grant_idx   = sbits'(i);
        end
      end
    end
  end

  assign acc_en = !full_q || out_rdy;
  assign accept = grant_found && acc_en && !rst;

  always_comb begin
    in_rdy = '0;
    if (accept) begin
      in_rdy[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    full_d = full_q;
    msg_d  = msg_q;
    sel_d  = sel_q;
    ptr_d  = ptr_q;
    if (accept) begin
      full_d = 1'b1;
      msg_d  = lanes[grant_idx];
      sel_d  = grant_idx;
      if (rr_mode) begin
        ptr_d = (grant_idx == sbits'(ninputs - 1)) ? '0 : grant_idx + 1'b1;
      end
    end else if (out_rdy) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      msg_q  <= '0;
      sel_q  <= '0;
      ptr_q  <= '0;
    end else begin
      full_q <= full_d;
      msg_q  <= msg_d;
      sel_q  <= sel_d;
      ptr_q  <= ptr_d;
    end
  end

  assign out_val = full_q;
  assign out_msg = msg_q;
  assign out_sel = sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: three instances (4-input RR, 4-input fixed priority,
// 3-input RR) checked every cycle against a queue-free behavioural model plus literals.
module tb_stream_mux_rr;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A: ninputs=4, round-robin
  logic [3:0]  val_a = '0, rdy_a;
  logic [31:0] msg_a = '0;
  logic        ordy_a = 1'b1, oval_a;
  logic [7:0]  omsg_a;
  logic [1:0]  osel_a;
  // Instance B: ninputs=4, fixed priority
  logic [3:0]  val_b = '0, rdy_b;
  logic [31:0] msg_b = '0;
  logic        ordy_b = 1'b1, oval_b;
  logic [7:0]  omsg_b;
  logic [1:0]  osel_b;
  // Instance C: ninputs=3, round-robin
  logic [2:0]  val_c = '0, rdy_c;
  logic [23:0] msg_c = '0;
  logic        ordy_c = 1'b1, oval_c;
  logic [7:0]  omsg_c;
  logic [1:0]  osel_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.nbits(8), .ninputs(4), .rr_mode(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_val(val_a), .in_rdy(rdy_a), .in_msg(msg_a),
    .out_val(oval_a), .out_rdy(ordy_a), .out_msg(omsg_a), .out_sel(osel_a)
  );
  stream_mux_rr #(.nbits(8), .ninputs(4), .rr_mode(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_val(val_b), .in_rdy(rdy_b), .in_msg(msg_b),
    .out_val(oval_b), .out_rdy(ordy_b), .out_msg(omsg_b), .out_sel(osel_b)
  );
  stream_mux_rr #(.nbits(8), .ninputs(3), .rr_mode(1'b1)) dut_c (
    .clk(clk), .rst(rst), .in_val(val_c), .in_rdy(rdy_c), .in_msg(msg_c),
    .out_val(oval_c), .out_rdy(ordy_c), .out_msg(omsg_c), .out_sel(osel_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model state per instance (reset values)
  bit       m_full [3] = '{0, 0, 0};
  logic [7:0] m_msg [3] = '{8'h0, 8'h0, 8'h0};
  int       m_sel  [3] = '{0, 0, 0};
  int       m_ptr  [3] = '{0, 0, 0};

  function automatic int grant_of(input logic [15:0] v, input int ptr, input int n, input bit rr);
    if (rr) begin
      for (int off = 0; off < n; off++) begin
        if (v[(ptr + off) % n]) return (ptr + off) % n;
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        if (v[i]) return i;
      end
    end
    return -1;
  endfunction

  // Compare current DUT outputs with the model, then advance the model using the
  // inputs that will be sampled at the next rising edge.
  task automatic model_cmp(input int k, input string tag, input int n, input bit rr,
                           input logic [15:0] v, input logic [127:0] m, input logic o,
                           input logic [15:0] a_rdy, input logic a_val,
                           input logic [7:0] a_msg, input logic [1:0] a_sel);
    int g;
    bit acc;
    logic [15:0] e_rdy;
    g = grant_of(v, m_ptr[k], n, rr);
    acc = !rst && (g >= 0) && (!m_full[k] || o);
    e_rdy = '0;
    if (acc) e_rdy[g] = 1'b1;
    check({tag, " in_rdy"}, {16'h0, a_rdy}, {16'h0, e_rdy});
    check({tag, " out_val"}, {31'h0, a_val}, {31'h0, m_full[k]});
    check({tag, " out_msg"}, {24'h0, a_msg}, {24'h0, m_msg[k]});
    check({tag, " out_sel"}, {30'h0, a_sel}, m_sel[k]);
    if (rst) begin
      m_full[k] = 1'b0; m_msg[k] = '0; m_sel[k] = 0; m_ptr[k] = 0;
    end else if (acc) begin
      m_full[k] = 1'b1;
      m_msg[k]  = m[g*8 +: 8];
      m_sel[k]  = g;
      if (rr) m_ptr[k] = (g + 1) % n;
    end else if (o) begin
      m_full[k] = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_cmp(0, "A", 4, 1'b1, {12'h0, val_a}, {96'h0, msg_a}, ordy_a,
                {12'h0, rdy_a}, oval_a, omsg_a, osel_a);
      model_cmp(1, "B", 4, 1'b0, {12'h0, val_b}, {96'h0, msg_b}, ordy_b,
                {12'h0, rdy_b}, oval_b, omsg_b, osel_b);
      model_cmp(2, "C", 3, 1'b1, {13'h0, val_c}, {104'h0, msg_c}, ordy_c,
                {13'h0, rdy_c}, oval_c, omsg_c, osel_c);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and single input
    cyc(); cyc();
    check("reset out_val", {31'h0, oval_a}, 32'h0);
    check("reset out_msg", {24'h0, omsg_a}, 32'h0);
    rst = 1'b0;
    val_a = 4'b0100; msg_a[16 +: 8] = 8'hA5; ordy_a = 1'b1;
    #1 check("single in_rdy", {28'h0, rdy_a}, 32'h4);
    cyc();
    val_a = '0;
    check("single out_val", {31'h0, oval_a}, 32'h1);
    check("single out_msg", {24'h0, omsg_a}, 32'hA5);
    check("single out_sel", {30'h0, osel_a}, 32'h2);
    cyc();

    // Round-robin contention from a fresh pointer
    rst = 1'b1; cyc(); rst = 1'b0;
    val_a = 4'hF; msg_a = 32'h13121110;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("rr out_sel", {30'h0, osel_a}, i % 4);
      check("rr out_msg", {24'h0, omsg_a}, 32'h10 + (i % 4));
    end
    val_a = '0; cyc();

    // Backpressure: hold 0x55 from input 1 while input 3 waits
    val_a = 4'b0010; msg_a = 32'h33005500; ordy_a = 1'b0;
    cyc();
    val_a = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall in_rdy", {28'h0, rdy_a}, 32'h0);
      check("stall out_msg", {24'h0, omsg_a}, 32'h55);
      check("stall out_sel", {30'h0, osel_a}, 32'h1);
      cyc();
    end
    ordy_a = 1'b1;
    #1 check("release in_rdy", {28'h0, rdy_a}, 32'h8);
    cyc();
    val_a = '0;
    check("release out_sel", {30'h0, osel_a}, 32'h3);
    check("release out_msg", {24'h0, omsg_a}, 32'h33);
    cyc();

    // Mid-operation reset: input 2 moves ptr to 3, reset must bring it back to 0
    val_a = 4'b0100; msg_a = 32'h00770000; ordy_a = 1'b0;
    cyc();
    val_a = '0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst out_val", {31'h0, oval_a}, 32'h0);
    val_a = 4'b1010; msg_a = 32'h23002100; ordy_a = 1'b1;
    #1 check("midrst in_rdy", {28'h0, rdy_a}, 32'h2);
    cyc();
    val_a = '0;
    check("midrst out_sel", {30'h0, osel_a}, 32'h1);
    check("midrst out_msg", {24'h0, omsg_a}, 32'h21);
    cyc();

    // Fixed priority: inputs 0 and 2 both valid
    val_b = 4'b0101; msg_b = 32'h00F200F0; ordy_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 check("fp in_rdy", {28'h0, rdy_b}, 32'h1);
      cyc();
      check("fp out_sel", {30'h0, osel_b}, 32'h0);
      check("fp out_msg", {24'h0, omsg_b}, 32'hF0);
    end
    val_b = '0; cyc();

    // Non-power-of-two wrap
    val_c = 3'b100; msg_c = 24'h323130; ordy_c = 1'b1;
    cyc();
    check("wrap out_sel2", {30'h0, osel_c}, 32'h2);
    val_c = 3'b011;
    cyc();
    check("wrap out_sel0", {30'h0, osel_c}, 32'h0);
    check("wrap out_msg0", {24'h0, omsg_c}, 32'h30);
    cyc();
    check("wrap out_sel1", {30'h0, osel_c}, 32'h1);
    val_c = '0;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
